// File: rtl/sync_ram_mrnw.sv
// ============================================================================
// sync_ram_mrnw : parametrised multi-read/multi-write register-file RAM with
// registered reads, optional write-to-read bypass and a sequential clear engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_ram_mrnw #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int NUM_RD     = 4,
   parameter int NUM_WR     = 2,
   parameter int BYPASS     = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
   input  logic [NUM_RD-1:0]            ren_i,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
   output logic [NUM_RD-1:0]            rvalid_o,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr_i,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
   input  logic [NUM_WR-1:0]            we_i,
   input  logic                         clear_i,
   output logic                         busy_o
);

   localparam int                    IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [IW-1:0]         LAST_IDX = IW'(DEPTH-1);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   state_e                          state_q, state_d;
   logic [IW-1:0]                   cnt_q, cnt_d;
   logic [NUM_RD*DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic [NUM_RD-1:0]               rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]           mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0]           ra [NUM_RD];
   logic [NUM_RD-1:0]               ra_ok;
   logic [ADDR_WIDTH-1:0]           wa [NUM_WR];
   logic [DATA_WIDTH-1:0]           wd [NUM_WR];
   logic [NUM_WR-1:0]               wr_act;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign ra[k]    = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign ra_ok[k] = ({1'b0, ra[k]} < DEPTH_A);
   end

   // A write is live only in READY and only for an in-range address.
   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
      assign wa[j]     = waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[j]     = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      assign wr_act[j] = we_i[j] && ({1'b0, wa[j]} < DEPTH_A) && (state_q == READY);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if (clear_i) begin
               cnt_d = '0;
            end else if (cnt_q == LAST_IDX) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (clear_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Later write ports are scanned last so the highest index wins on a tie.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if ((state_q == READY) && ren_i[k]) begin
            rvalid_d[k] = 1'b1;
            rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = ra_ok[k] ? mem_q[ra[k][IW-1:0]] : '0;
            if (BYPASS != 0) begin
               for (int j = 0; j < NUM_WR; j++) begin
                  if (wr_act[j] && (wa[j] == ra[k])) begin
                     rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = wd[j];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == CLEAR) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_act[j]) begin
               mem_q[wa[j][IW-1:0]] <= wd[j];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= CLEAR;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign busy_o   = (state_q == CLEAR);

endmodule

`default_nettype wire

// File: doc/sync_ram_mrnw.md
# sync_ram_mrnw

Parametrised multi-read/multi-write synchronous register-file RAM for the dispatch stage. It generalises the fixed 4-read/2-write array to any number of read and write ports. It adds per-port read enables with valid flags, optional write-to-read bypass, and deterministic write-conflict priority. A sequential clear engine zeroes the whole array after reset or on request.

## Interface
- ADDR_WIDTH, 5: address bits per port.
- DATA_WIDTH, 32: data bits per entry.
- DEPTH, 32: number of entries; must be ≤ 2^ADDR_WIDTH.
- NUM_RD, 4: number of read ports (≥1).
- NUM_WR, 2: number of write ports (≥1).
- BYPASS, 1: 1 = a same-cycle write is forwarded to a matching read; 0 = the read returns the old data.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- raddr_i  in  NUM_RD*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- ren_i  in  NUM_RD  per-port read enable.
- rdata_o  out  NUM_RD*DATA_WIDTH  registered read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- rvalid_o  out  NUM_RD  rdata_o slice k is valid this cycle.
- waddr_i  in  NUM_WR*ADDR_WIDTH  write addresses, packed the same way as raddr_i.
- wdata_i  in  NUM_WR*DATA_WIDTH  write data, packed the same way as rdata_o.
- we_i  in  NUM_WR  per-port write enable.
- clear_i  in  1  synchronous request to zero the array.
- busy_o  out  1  clear engine active; writes and reads are blocked.

## Operation
- State machine: CLEAR and READY.
  - Reset enters CLEAR with clear counter = 0.
  - CLEAR: each cycle writes 0 to mem[counter] and increments the counter. When counter = DEPTH-1 is written, the state goes to READY.
  - READY: clear_i = 1 enters CLEAR with counter = 0 on the next edge. The READY-cycle operations in that same cycle still complete normally.
  - clear_i asserted during CLEAR restarts the counter at 0.
- busy_o = (state == CLEAR).
- While busy_o = 1:
  - all we_i are ignored;
  - reads produce rvalid_o = 0;
  - rdata_o holds its value.
- Writes in READY: each port j with we_i[j] = 1 and waddr < DEPTH writes wdata_i[j].
  - Several ports writing the same address in one cycle: the highest-indexed port wins.
  - waddr ≥ DEPTH: the write is dropped silently.
- Reads in READY, when ren_i[k] = 1:
  - rdata_o[k] is loaded at the edge with mem[raddr_k].
  - rvalid_o[k] is set to 1 for the following cycle.
  - raddr_k ≥ DEPTH returns 0.
- Read bypass:
  - BYPASS = 1: if any active write in the same cycle targets raddr_k, rdata_o[k] gets the winning (highest-indexed) wdata.
  - BYPASS = 0: rdata_o[k] gets the pre-write contents.
- ren_i[k] = 0: rdata_o[k] holds its previous value and rvalid_o[k] = 0.
- The memory array itself is not reset asynchronously. Its contents are defined only after the CLEAR sequence completes.

## Timing
- Reset (rst_ni = 0, asynchronous):
  - rdata_o = 0, rvalid_o = 0;
  - busy_o = 1, state = CLEAR, counter = 0.
- After rst_ni rises:
  - busy_o stays 1 for exactly DEPTH rising edges;
  - the first edge with busy_o = 0 accepts writes and reads.
- Read latency: 1 cycle. An address presented with ren_i at edge N gives data and rvalid_o valid after edge N, through to edge N+1.
- Write latency: 1 cycle.
  - A non-bypassed read at edge N+1 sees a write committed at edge N.
  - With BYPASS = 1, a read at edge N itself sees that write.
- clear_i in READY at edge N:
  - busy_o = 1 from after edge N;
  - READY returns after edge N+DEPTH.
- Reset asserted mid-CLEAR or mid-operation: immediate return to the reset values above; the clear restarts from entry 0.

## Test plan
- Clear after reset: release rst_ni, count cycles.
  - busy_o is high for exactly 32 cycles.
  - A read of every address then returns 0 with rvalid_o = 1.
- Basic write/read: write 0xDEADBEEF to addr 5 via port 0, then read addr 5 on all 4 ports the next cycle → every rdata slice = 0xDEADBEEF with rvalid_o = 4'b1111.
- Write conflict: port 0 writes 0x11 and port 1 writes 0x22, both to addr 7 in the same cycle. A later read of addr 7 → 0x22.
- Bypass: addr 3 holds 0xAA. In one cycle, write 0xBB to addr 3 and read addr 3.
  - BYPASS = 1 → 0xBB.
  - BYPASS = 0 → 0xAA, and the next read → 0xBB.
- Clear and range checks: assert clear_i mid-traffic.
  - Writes during the 32 busy cycles are ignored and rvalid_o = 0.
  - Afterwards all entries read 0.
  - A write to addr 40 with DEPTH = 32 (ADDR_WIDTH = 6) is dropped, and a read of addr 40 returns 0.
- Reset mid-clear: pull rst_ni low at clear cycle 10 → outputs go to the reset values immediately. After release, busy_o is high for the full 32 cycles.
